// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed segment bus in, decoded frame out over valid/ready.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [6:0]              seg_in;
    logic                    dp_in;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [4*NUM_DIGITS-1:0] frame_value;
    logic [NUM_DIGITS-1:0]   frame_dp;
    logic [NUM_DIGITS-1:0]   frame_err;
    logic                    frame_valid;
    logic                    frame_ready;
    logic                    overrun;
    modport master (
        output seg_in, dp_in, dig_en, frame_ready,
        input  frame_value, frame_dp, frame_err, frame_valid, overrun
    );
    modport slave (
        input  seg_in, dp_in, dig_en, frame_ready,
        output frame_value, frame_dp, frame_err, frame_valid, overrun
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers per-digit hex values from a multiplexed 7-segment bus into frames.
// Define SEG7_ACTIVE_LOW_EN for common-anode inputs (0 = lit / selected).
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int SW = NUM_DIGITS + 8;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} smp_t;
    typedef enum logic {F_COLLECT, F_PRESENT} frm_t;
    logic [SW-1:0]           w_in, r_s, r_prev;
    logic [NUM_DIGITS-1:0]   w_dig, r_mask, r_bdp, r_berr, r_fdp, r_ferr;
    logic [4*NUM_DIGITS-1:0] r_bval, r_fval;
    logic [3:0]              r_cnt;
    logic [4:0]              w_dec;
    logic                    w_oh, w_chg, w_cap, w_full, w_hs, w_load, w_ovr, r_ovr;
    smp_t                    r_sst, w_snext;
    frm_t                    r_fst, w_fnext;
`ifdef SEG7_ACTIVE_LOW_EN
    assign w_in = ~{bus.dig_en, bus.dp_in, bus.seg_in};
`else
    assign w_in = {bus.dig_en, bus.dp_in, bus.seg_in};
`endif
    assign w_dig  = r_s[SW-1:8];
    assign w_oh   = $onehot(w_dig);
    assign w_chg  = r_s != r_prev;
    assign w_full = &r_mask;
    assign w_hs   = (r_fst == F_PRESENT) && bus.frame_ready;
    // {err, value}
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction
    assign w_dec = decode(r_s[6:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_s    <= w_in;
            r_prev <= r_s;
            r_cnt  <= (w_chg || !w_oh) ? 4'd0 : (r_cnt == 4'(STABLE_CYCLES)) ? r_cnt : r_cnt + 4'd1;
        end
    end
    always_ff @(posedge clk) r_sst <= rst ? S_IDLE : w_snext;
    // The buffer write fires on the edge that enters CAPTURE, so the capture lands at E0+STABLE_CYCLES.
    always_comb w_snext = !w_oh ? S_IDLE :
                          (r_sst == S_IDLE || w_chg) ? S_SETTLE :
                          (r_sst != S_SETTLE) ? S_HOLD :
                          (r_cnt >= 4'(STABLE_CYCLES - 2)) ? S_CAPTURE : S_SETTLE;
    always_comb w_cap = (r_sst == S_SETTLE) && (w_snext == S_CAPTURE);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bval <= '0;
            r_bdp  <= '0;
            r_berr <= '0;
            r_mask <= '0;
        end else begin
            r_mask <= (r_mask & {NUM_DIGITS{!w_full}}) | (w_dig & {NUM_DIGITS{w_cap}});
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_cap && w_dig[i]) begin
                    r_bval[4*i+:4] <= w_dec[3:0];
                    r_bdp[i]       <= r_s[7];
                    r_berr[i]      <= w_dec[4];
                end
            end
        end
    end
    always_ff @(posedge clk) r_fst <= rst ? F_COLLECT : w_fnext;
    always_comb w_fnext = (w_full || (r_fst == F_PRESENT && !w_hs)) ? F_PRESENT : F_COLLECT;
    always_comb begin
        w_load = w_full && (r_fst == F_COLLECT || w_hs);
        w_ovr  = w_full && (r_fst == F_PRESENT) && !w_hs;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fval <= '0;
            r_fdp  <= '0;
            r_ferr <= '0;
            r_ovr  <= 1'b0;
        end else begin
            r_ovr <= w_ovr;
            if (w_load) begin
                r_fval <= r_bval;
                r_fdp  <= r_bdp;
                r_ferr <= r_berr;
            end
        end
    end
    assign bus.frame_value = r_fval;
    assign bus.frame_dp    = r_fdp;
    assign bus.frame_err   = r_ferr;
    assign bus.frame_valid = (r_fst == F_PRESENT);
    assign bus.overrun     = r_ovr;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: vector table, hand sequences and random scans checked against a
// run-length reference model of the display bus.
module tb_seg7_scan_decoder;
    localparam int ND = 4;
    localparam int NS = 3;
    typedef struct {
        logic [ND-1:0]   dig;
        logic [6:0]      seg;
        logic            dp;
        logic            rdy;
        int              cyc;
        logic [4*ND-1:0] val;
        logic [ND-1:0]   dpx;
        logic [ND-1:0]   err;
        logic            v;
        logic            o;
    } vec_t;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ND-1:0]   d_dig = '0;
    logic [6:0]      d_seg = '0;
    logic            d_dp = 1'b0;
    logic            d_rdy = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;
    logic [6:0]      pat [16];
    vec_t            tv [20];
    logic [ND+7:0]   m_prev;
    int              m_run;
    logic [4*ND-1:0] m_bval, m_fval;
    logic [ND-1:0]   m_bdp, m_berr, m_mask, m_fdp, m_ferr;
    logic            m_valid, m_ovr;
    seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();
    seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(NS)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
`ifdef SEG7_ACTIVE_LOW_EN
    assign bus.seg_in = ~d_seg;
    assign bus.dp_in  = ~d_dp;
    assign bus.dig_en = ~d_dig;
`else
    assign bus.seg_in = d_seg;
    assign bus.dp_in  = d_dp;
    assign bus.dig_en = d_dig;
`endif
    assign bus.frame_ready = d_rdy;
    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        for (int k = 0; k < 16; k++) if (pat[k] == s) return {1'b0, 4'(k)};
        return 5'h10;
    endfunction
    function automatic logic [6*ND+1:0] dut_out();
        return {bus.frame_value, bus.frame_dp, bus.frame_err, bus.frame_valid, bus.overrun};
    endfunction
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask
    // A digit is captured once a run of identical one-hot samples reaches NS samples.
    task automatic model_edge();
        logic [ND+7:0] cur;
        logic [4:0]    dv;
        logic          full, hs;
        cur = {d_dig, d_dp, d_seg};
        if (rst) begin
            m_prev = '0; m_run = 1; m_bval = '0; m_bdp = '0; m_berr = '0; m_mask = '0;
            m_fval = '0; m_fdp = '0; m_ferr = '0; m_valid = 1'b0; m_ovr = 1'b0;
            return;
        end
        full  = (m_mask == '1);
        hs    = m_valid && d_rdy;
        m_ovr = full && m_valid && !hs;
        if (full && (!m_valid || hs)) begin
            m_fval = m_bval; m_fdp = m_bdp; m_ferr = m_berr; m_valid = 1'b1;
        end else if (hs) m_valid = 1'b0;
        if (full) m_mask = '0;
        if (m_run == NS && $onehot(m_prev[ND+7:8])) begin
            dv = ref_dec(m_prev[6:0]);
            for (int d = 0; d < ND; d++) begin
                if (m_prev[8+d]) begin
                    m_bval[4*d+:4] = dv[3:0]; m_berr[d] = dv[4]; m_bdp[d] = m_prev[7]; m_mask[d] = 1'b1;
                end
            end
        end
        m_run  = (cur == m_prev) ? m_run + 1 : 1;
        m_prev = cur;
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", 64'(dut_out()), 64'({m_fval, m_fdp, m_ferr, m_valid, m_ovr}));
    endtask
    task automatic hold(input logic [ND-1:0] dg, input logic [6:0] sg, input logic dp, input logic rdy, input int n);
        d_dig = dg; d_seg = sg; d_dp = dp; d_rdy = rdy;
        repeat (n) tick();
    endtask
    initial begin
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        tv[0]  = '{4'b0001, 7'h06, 1'b0, 1'b1, 6, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[1]  = '{4'b0010, 7'h5B, 1'b0, 1'b1, 6, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[2]  = '{4'b0100, 7'h4F, 1'b0, 1'b1, 6, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[3]  = '{4'b1000, 7'h66, 1'b0, 1'b1, 5, 16'h4321, 4'h0, 4'h0, 1'b1, 1'b0};
        tv[4]  = '{4'b1000, 7'h66, 1'b0, 1'b1, 1, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[5]  = '{4'b0001, 7'h3F, 1'b1, 1'b1, 6, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[6]  = '{4'b0010, 7'h49, 1'b0, 1'b1, 6, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[7]  = '{4'b0100, 7'h00, 1'b0, 1'b1, 6, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0};
        tv[8]  = '{4'b1000, 7'h7D, 1'b0, 1'b1, 5, 16'h6000, 4'h1, 4'h6, 1'b1, 1'b0};
        tv[9]  = '{4'b1000, 7'h7D, 1'b0, 1'b1, 1, 16'h6000, 4'h1, 4'h6, 1'b0, 1'b0};
        tv[10] = '{4'b0001, 7'h77, 1'b0, 1'b0, 6, 16'h6000, 4'h1, 4'h6, 1'b0, 1'b0};
        tv[11] = '{4'b0010, 7'h7C, 1'b0, 1'b0, 6, 16'h6000, 4'h1, 4'h6, 1'b0, 1'b0};
        tv[12] = '{4'b0100, 7'h39, 1'b0, 1'b0, 6, 16'h6000, 4'h1, 4'h6, 1'b0, 1'b0};
        tv[13] = '{4'b1000, 7'h5E, 1'b0, 1'b0, 6, 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b0};
        tv[14] = '{4'b0001, 7'h79, 1'b0, 1'b0, 6, 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b0};
        tv[15] = '{4'b0010, 7'h71, 1'b0, 1'b0, 6, 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b0};
        tv[16] = '{4'b0100, 7'h7F, 1'b0, 1'b0, 6, 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b0};
        tv[17] = '{4'b1000, 7'h6F, 1'b0, 1'b0, 5, 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b1};
        tv[18] = '{4'b1000, 7'h6F, 1'b0, 1'b0, 1, 16'hDCBA, 4'h0, 4'h0, 1'b1, 1'b0};
        tv[19] = '{4'b1000, 7'h6F, 1'b0, 1'b1, 1, 16'hDCBA, 4'h0, 4'h0, 1'b0, 1'b0};
        tick(); tick();
        chk("reset_state", 64'(dut_out()), 64'd0);
        rst = 1'b0;
        hold(4'b0010, 7'h06, 1'b0, 1'b1, 6);
        hold(4'b0100, 7'h5B, 1'b0, 1'b1, 6);
        hold(4'b1000, 7'h4F, 1'b0, 1'b1, 6);
        hold(4'b0001, 7'h3F, 1'b1, 1'b1, 4);
        chk("latency_pre", 64'(bus.frame_valid), 64'd0);
        tick();
        chk("latency_frame", 64'({bus.frame_value, bus.frame_dp, bus.frame_err, bus.frame_valid}),
            64'({16'h3210, 4'b0001, 4'b0000, 1'b1}));
        tick();
        chk("handshake_drop", 64'(bus.frame_valid), 64'd0);
        d_dig = '0; d_seg = '0; d_dp = 1'b0; rst = 1'b1;
        tick();
        chk("reset_idle", 64'(dut_out()), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hold(tv[i].dig, tv[i].seg, tv[i].dp, tv[i].rdy, tv[i].cyc);
            chk($sformatf("vec%0d", i), 64'(dut_out()), 64'({tv[i].val, tv[i].dpx, tv[i].err, tv[i].v, tv[i].o}));
        end
        hold(4'b0010, 7'h06, 1'b0, 1'b1, 6);
        hold(4'b0100, 7'h5B, 1'b0, 1'b1, 6);
        hold(4'b1000, 7'h4F, 1'b0, 1'b1, 6);
        hold(4'b0011, 7'h3F, 1'b0, 1'b1, 5);
        hold(4'b0001, 7'h66, 1'b0, 1'b1, 2);
        hold(4'b0001, 7'h6D, 1'b0, 1'b1, 2);
        hold(4'b0001, 7'h7D, 1'b0, 1'b1, 4);
        chk("glitch_nocap", 64'(bus.frame_valid), 64'd0);
        tick();
        chk("glitch_frame", 64'({bus.frame_value, bus.frame_err, bus.frame_valid}), 64'({16'h3216, 4'h0, 1'b1}));
        tick();
        hold(4'b0001, 7'h06, 1'b0, 1'b1, 6);
        hold(4'b0010, 7'h5B, 1'b0, 1'b1, 6);
        hold(4'b0100, 7'h4F, 1'b0, 1'b1, 2);
        rst = 1'b1;
        tick();
        chk("reset_settle", 64'(dut_out()), 64'd0);
        rst = 1'b0;
        hold(4'b0100, 7'h4F, 1'b0, 1'b1, 6);
        hold(4'b1000, 7'h66, 1'b0, 1'b1, 6);
        chk("settle_mask_cleared", 64'(bus.frame_valid), 64'd0);
        hold(4'b0001, 7'h06, 1'b0, 1'b1, 6);
        hold(4'b0010, 7'h5B, 1'b0, 1'b1, 4);
        chk("rescan_pre", 64'(bus.frame_valid), 64'd0);
        tick();
        chk("rescan_frame", 64'({bus.frame_value, bus.frame_valid}), 64'({16'h4321, 1'b1}));
        tick();
        hold(4'b0001, 7'h3F, 1'b1, 1'b0, 6);
        hold(4'b0010, 7'h3F, 1'b0, 1'b0, 6);
        hold(4'b0100, 7'h3F, 1'b0, 1'b0, 6);
        hold(4'b1000, 7'h3F, 1'b0, 1'b0, 6);
        chk("present_valid", 64'(bus.frame_valid), 64'd1);
        hold(4'b0001, 7'h06, 1'b0, 1'b0, 6);
        rst = 1'b1;
        tick();
        chk("reset_present", 64'(dut_out()), 64'd0);
        rst = 1'b0;
        hold(4'b0010, 7'h06, 1'b0, 1'b1, 6);
        hold(4'b0100, 7'h06, 1'b0, 1'b1, 6);
        hold(4'b1000, 7'h06, 1'b0, 1'b1, 6);
        chk("present_mask_cleared", 64'(bus.frame_valid), 64'd0);
        hold(4'b0001, 7'h7F, 1'b0, 1'b1, 4);
        chk("present_rescan_pre", 64'(bus.frame_valid), 64'd0);
        tick();
        chk("present_rescan", 64'({bus.frame_value, bus.frame_valid}), 64'({16'h1118, 1'b1}));
        for (int s = 0; s < 300; s++) begin
            int            r;
            logic [ND-1:0] dg;
            logic [6:0]    sg;
            r  = $urandom_range(0, 9);
            dg = (r < 8) ? ND'(1 << $urandom_range(0, ND - 1)) : (r == 8) ? '0 : ND'($urandom_range(0, (1 << ND) - 1));
            sg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : pat[$urandom_range(0, 15)];
            rst = ($urandom_range(0, 59) == 0);
            hold(dg, sg, 1'($urandom), 1'($urandom_range(0, 2) != 0), rst ? 1 : int'($urandom_range(1, 7)));
            rst = 1'b0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receiving end of the 7-segment display interface: watches a multiplexed segment bus (segments a..g, dp, per-digit enable strobes) and recovers the hex value shown on each digit.
- Filters scan transitions with a stability counter and assembles one complete frame per scan of all digits.
- Presents the frame over a valid/ready handshake.
- Used as a loopback checker for display-driver circuits and as a front end for reading external multiplexed displays.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 3, consecutive identical registered samples required before a capture (2..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_in  input  7  segment levels, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, 1=lit.
- dp_in  input  1  decimal point level, 1=lit.
- dig_en  input  NUM_DIGITS  digit strobes, one-hot, bit i selects digit i.
- frame_value  output  4*NUM_DIGITS  decoded nibble per digit, digit i at [4i+3:4i].
- frame_dp  output  NUM_DIGITS  captured dp per digit.
- frame_err  output  NUM_DIGITS  1 = digit pattern not in decode table.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts frame.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset: all outputs 0; capture buffer, per-digit captured mask and stability counter cleared; sample FSM to IDLE; frame FSM to COLLECT.
- Input stage: {dig_en, dp_in, seg_in} registered once into sample register S every cycle.
- Stability counter: cleared when S differs from its previous value or S.dig_en is not one-hot; otherwise increments, saturating at STABLE_CYCLES.
- Sample FSM:
  - IDLE: dig_en is zero or multi-hot. Stay in IDLE while that holds. Go to SETTLE once S.dig_en becomes one-hot.
  - SETTLE: counting. Go to CAPTURE when the count reaches STABLE_CYCLES-1 with S unchanged. Go back to IDLE or restart SETTLE on any change.
  - CAPTURE: one cycle. Write the digit buffer and set the mask bit, then go to HOLD.
  - HOLD: no further capture until S changes; on change go to SETTLE or IDLE.
- Capture timing: with inputs constant from edge E0 (the first edge that registers them), the capture takes effect at edge E0+STABLE_CYCLES.
- Decode table (seg_in -> value), err=0:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7
  - 0x7F->8, 0x6F->9, 0x77->A, 0x7C->B, 0x39->C, 0x5E->D, 0x79->E, 0x71->F
  - Any other pattern, including blank 0x00: value=0, err=1.
- Re-capture of the same digit before the frame completes overwrites that digit's entry.
- Frame FSM:
  - COLLECT: when all NUM_DIGITS mask bits are set, copy the buffer to the frame outputs on the next edge, raise frame_valid, clear the mask, go to PRESENT.
  - PRESENT: outputs held stable. The handshake completes on a cycle with frame_valid && frame_ready; at that edge frame_valid drops and the FSM returns to COLLECT. Capture continues into the buffer meanwhile.
  - While in PRESENT, if the mask completes again: the new frame is discarded, overrun pulses for 1 cycle, and the mask is cleared.
  - If the mask completes on the same edge as the handshake: the new frame is loaded and frame_valid stays high, with no overrun.
- frame_ready while frame_valid=0: ignored.
- Reset mid-capture or mid-PRESENT: everything returns to reset values on that edge, and the pending frame is lost.

Optional Feature:
- Macro SEG7_ACTIVE_LOW_EN.
- Defined: seg_in, dp_in and dig_en are inverted ahead of the input register (common-anode displays, 0=lit/selected). All other behaviour is unchanged.
- Undefined: active-high inputs as specified above.

Test Plan:
- Reset, then hold dig_en=0001, seg_in=0x3F, dp_in=1 from edge E0 -> capture at E0+3, digit0 value 0, dp 1, err 0; frame_valid stays 0 until the other digits are captured.
- Scan digits 0..3 with patterns 0x06, 0x5B, 0x4F, 0x66, 6 cycles each, frame_ready=1 -> frame_value=0x4321, frame_err=0, frame_valid for 1 cycle.
- Digit 2 shows 0x00 and digit 1 shows 0x49 -> frame_err=0110, those nibbles 0.
- Glitch: dig_en=0011 for 5 cycles, then a 2-cycle pattern change within a strobe -> no capture during the glitch; capture only after 3 stable samples.
- Hold frame_ready=0 across two complete scans -> first frame held unchanged, overrun pulses once, frame_valid stays 1. Then assert frame_ready for 1 cycle -> frame_valid drops.
- Assert rst during SETTLE and during PRESENT -> next cycle all outputs 0 and the mask cleared. A full scan is then needed before frame_valid rises again.
